// File: rtl/mips_regfile_wb_if.sv
// -----------------------------------------------------------------------------
// mips_regfile_wb_if
//   Bundle of write-back and decode-read signals for mips_regfile_wb.
//
//   Signals:
//     wr_en      RegWrite from control; write request this cycle
//     wr_addr    destination register (rd/rt after RegDst)
//     wr_data    write-back word from the MemToReg multiplexer
//     rd_addr1   read port 1 address (rs)
//     rd_addr2   read port 2 address (rt)
//     rd_data1   read port 1 data, combinational
//     rd_data2   read port 2 data, combinational
//     pend_valid a write is staged and not yet committed
//     wr_count   writes committed to the array since reset
//
//   Modports:
//     master  datapath side (drives the write and read addresses)
//     slave   register file side
// -----------------------------------------------------------------------------
interface mips_regfile_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          pend_valid;
  logic [31:0]   wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, pend_valid, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, pend_valid, wr_count
  );
endinterface

// File: rtl/mips_regfile_wb.sv
// -----------------------------------------------------------------------------
// mips_regfile_wb
//   Write-back register file for the single-issue MIPS datapath. The
//   write-back word is staged for one cycle in a pending-write register and
//   committed to a 32 x 32 register array on the following edge. Two
//   combinational read ports serve the decode stage; committed writes are
//   counted for debug.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    mips_regfile_wb_if.slave (write request, read ports,
//            pend_valid, wr_count)
//
//   Build option:
//     MIPS_REGFILE_BYPASS_EN  when defined, a read hitting the nonzero
//       pending address returns the pending data, making a write visible one
//       cycle earlier. The current-cycle wr_data is never bypassed. When
//       undefined, reads see array contents only and the hazard logic must
//       insert the extra bubble.
// -----------------------------------------------------------------------------
module mips_regfile_wb #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_regfile_wb_if.slave  bus
);

  localparam int AW = 5;

  logic [DW-1:0] regs [NREGS];

  logic          vld_p1;
  logic [AW-1:0] pend_addr_p1;
  logic [DW-1:0] pend_data_p1;
  logic [31:0]   wr_count_q;

  logic [DW-1:0] rd_data1_c;
  logic [DW-1:0] rd_data2_c;

  // Commit of the staged write happens before the new capture in the same
  // edge, so a pending write and a fresh write to the same register both
  // land in order and neither is lost.
  function automatic logic [31:0] count_inc(input logic [31:0] cnt);
    return cnt + 32'd1;
  endfunction

  // ---- p0 -> p1: capture write-back into the pending register; p1 -> array:
  // commit staged write ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      vld_p1       <= 1'b0;
      pend_addr_p1 <= '0;
      pend_data_p1 <= '0;
      wr_count_q   <= '0;
    end else begin
      if (vld_p1) begin
        regs[pend_addr_p1] <= pend_data_p1;
        wr_count_q         <= count_inc(wr_count_q);
      end
      // Writes to register 0 are dropped here so they never commit or count.
      vld_p1       <= bus.wr_en && (bus.wr_addr != '0);
      pend_addr_p1 <= bus.wr_addr;
      pend_data_p1 <= bus.wr_data;
    end
  end

  // ---- read ports (combinational) ----
  always_comb begin
    rd_data1_c = (bus.rd_addr1 == '0) ? '0 : regs[bus.rd_addr1];
    rd_data2_c = (bus.rd_addr2 == '0) ? '0 : regs[bus.rd_addr2];
`ifdef MIPS_REGFILE_BYPASS_EN
    // vld_p1 already implies a nonzero pending address.
    if (vld_p1 && (bus.rd_addr1 == pend_addr_p1)) begin
      rd_data1_c = pend_data_p1;
    end
    if (vld_p1 && (bus.rd_addr2 == pend_addr_p1)) begin
      rd_data2_c = pend_data_p1;
    end
`endif
  end

  assign bus.rd_data1   = rd_data1_c;
  assign bus.rd_data2   = rd_data2_c;
  assign bus.pend_valid = vld_p1;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_mips_regfile_wb.sv
module tb_mips_regfile_wb;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mips_regfile_wb_if bus ();

  mips_regfile_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MIPS_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    set_wr(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Junk writes, committed, then reset while another write is presented.
    set_wr(1'b1, 5'd1, 32'hAAAA5555);
    tick();
    set_wr(1'b1, 5'd2, 32'h00001234);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    tick();
    bus.rd_addr1 = 5'd1;
    bus.rd_addr2 = 5'd2;
    #1;
    check("junk_r1", bus.rd_data1, 32'hAAAA5555);
    check("junk_r2", bus.rd_data2, 32'h00001234);
    check("junk_cnt", bus.wr_count, 32'd2);

    rst_n = 1'b0;
    set_wr(1'b1, 5'd3, 32'h00000077);
    tick();
    tick();
    rst_n = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    check("rst_pend", {31'b0, bus.pend_valid}, 32'd0);
    check("rst_cnt", bus.wr_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr1 = i[4:0];
      bus.rd_addr2 = 5'd31 - i[4:0];
      #1;
      check($sformatf("rst_rd1_%0d", i), bus.rd_data1, 32'h0);
      check($sformatf("rst_rd2_%0d", i), bus.rd_data2, 32'h0);
    end
    tick();
    bus.rd_addr1 = 5'd3;
    #1;
    check("rst_wr_ignored", bus.rd_data1, 32'h0);
    check("rst_wr_nocnt", bus.wr_count, 32'd0);

    // Single write to reg 5.
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    bus.rd_addr1 = 5'd5;
    #1;
    check("no_cur_bypass", bus.rd_data1, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("sw_pend", {31'b0, bus.pend_valid}, 32'd1);
    check("sw_cnt_n1", bus.wr_count, 32'd0);
    check("sw_rd_n1", bus.rd_data1, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    check("sw_rd_n2", bus.rd_data1, 32'hDEADBEEF);
    check("sw_pend_n2", {31'b0, bus.pend_valid}, 32'd0);
    check("sw_cnt_n2", bus.wr_count, 32'd1);

    // Register 0 write is discarded.
    set_wr(1'b1, 5'd0, 32'h12345678);
    bus.rd_addr1 = 5'd0;
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_pend", {31'b0, bus.pend_valid}, 32'd0);
    check("r0_rd_n1", bus.rd_data1, 32'h0);
    tick();
    check("r0_rd_n2", bus.rd_data1, 32'h0);
    check("r0_cnt", bus.wr_count, 32'd1);

    // Back-to-back writes to reg 7: later value wins, both counted.
    set_wr(1'b1, 5'd7, 32'h00000001);
    bus.rd_addr1 = 5'd7;
    tick();
    set_wr(1'b1, 5'd7, 32'h00000002);
    #1;
    check("b2b_c1", bus.rd_data1, BYP ? 32'h1 : 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("b2b_c2", bus.rd_data1, BYP ? 32'h2 : 32'h1);
    check("b2b_pend_c2", {31'b0, bus.pend_valid}, 32'd1);
    check("b2b_cnt_c2", bus.wr_count, 32'd2);
    tick();
    check("b2b_c3", bus.rd_data1, 32'h2);
    check("b2b_cnt_c3", bus.wr_count, 32'd3);

    // Dual read of regs 3 and 4.
    set_wr(1'b1, 5'd3, 32'h0000000A);
    tick();
    set_wr(1'b1, 5'd4, 32'h0000000B);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    tick();
    bus.rd_addr1 = 5'd3;
    bus.rd_addr2 = 5'd4;
    #1;
    check("dual_rd1", bus.rd_data1, 32'hA);
    check("dual_rd2", bus.rd_data2, 32'hB);
    check("dual_cnt", bus.wr_count, 32'd5);

    // Reset while reg 9 write is pending: it is dropped.
    set_wr(1'b1, 5'd9, 32'h00000055);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.rd_addr1 = 5'd9;
    bus.rd_addr2 = 5'd5;
    #1;
    check("mid_rst_r9", bus.rd_data1, 32'h0);
    check("mid_rst_r5", bus.rd_data2, 32'h0);
    check("mid_rst_cnt", bus.wr_count, 32'd0);
    check("mid_rst_pend", {31'b0, bus.pend_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
